// File: rtl/timer_chain_ctrl_pkg.sv
// Shared types and constants for the timer_chain_ctrl interval timer.
// FSM states, register map and ctrl bit positions.
package timer_chain_ctrl_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } tstate_t;

  localparam logic [1:0] ADDR_LO   = 2'd0;
  localparam logic [1:0] ADDR_HI   = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_ACK  = 2'd3;

  localparam int CTRL_RUN       = 0;
  localparam int CTRL_PERIODIC  = 1;
  localparam int CTRL_DONE      = 2;
  localparam int CTRL_PRESC_LSB = 4;

  function automatic logic [7:0] ctrl_byte(
    input logic [3:0] presc,
    input logic       done,
    input logic       periodic,
    input logic       running
  );
    return {presc, 1'b0, done, periodic, running};
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the CLK strobe by (div+1) to form the counter tick.
// clr restarts the division and suppresses any tick in that cycle.
module timer_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  MasterClock,
  input  logic                  RESETL,
  input  logic                  clr,
  input  logic                  CLK,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;

  assign tick = CLK && !clr && (pcnt == div);

  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      pcnt <= '0;
    end else if (clr || tick) begin
      pcnt <= '0;
    end else if (CLK) begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_chain_ctrl.sv
// CPU-programmable interval timer sequencing a toggle-cell counter chain.
// Define TIMER_CHAIN_CTRL_LATCH_EN for a coherent hi-byte read shadow.
module timer_chain_ctrl
  import timer_chain_ctrl_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 4
) (
  input  logic             MasterClock,
  input  logic             RESETL,
  input  logic             CLK,
  input  logic             wr_en,
  input  logic [1:0]       addr,
  input  logic [7:0]       wr_data,
`ifdef TIMER_CHAIN_CTRL_LATCH_EN
  input  logic             rd_en,
`endif
  output logic [7:0]       rd_data,
  output logic             irq,
  output logic [WIDTH-1:0] count,
  output logic             running
);

  tstate_t state, state_nxt;

  logic [15:0]           reload_q;
  logic [WIDTH-1:0]      reload;
  logic [WIDTH-1:0]      count_nxt;
  logic [WIDTH-1:0]      inc;
  logic [WIDTH:0]        carry;
  logic [PRESCALE_W-1:0] presc;
  logic [15:0]           cnt_ext;
  logic [7:0]            hi_byte;

  logic periodic, done_flag, done_nxt;
  logic set_irq, pclr, tick, step, terminal;
  logic sel_lo, sel_hi, sel_ctrl, sel_ack;
  logic ctrl_wr, ack_wr, start;
  logic unused_bits;

  assign sel_lo   = (addr == ADDR_LO);
  assign sel_hi   = (addr == ADDR_HI);
  assign sel_ctrl = (addr == ADDR_CTRL);
  assign sel_ack  = (addr == ADDR_ACK);

  assign ctrl_wr = wr_en && sel_ctrl;
  assign ack_wr  = wr_en && sel_ack;
  assign start   = wr_data[CTRL_RUN];

  assign reload  = reload_q[WIDTH-1:0];
  assign running = (state == RUN);
  assign cnt_ext = 16'(count);

  assign unused_bits = wr_data[3];

  timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_presc (
    .MasterClock(MasterClock),
    .RESETL     (RESETL),
    .clr        (pclr),
    .CLK        (CLK),
    .div        (presc),
    .tick       (tick)
  );

  // A ctrl write in RUN pre-empts the tick: stop or restart wins.
  assign step     = tick && running && !ctrl_wr;
  assign carry[0] = step;
  assign terminal = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign inc[i]     = count[i] ^ carry[i];
    assign carry[i+1] = carry[i] & count[i];
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = done_flag;
    set_irq   = 1'b0;
    pclr      = 1'b0;
    unique case (state)
      STOP, DONE: begin
        if (ctrl_wr && start) state_nxt = ARM;
      end
      ARM: begin
        count_nxt = reload;
        done_nxt  = 1'b0;
        pclr      = 1'b1;
        if (ctrl_wr) state_nxt = start ? ARM : STOP;
        else         state_nxt = RUN;
      end
      RUN: begin
        if (ctrl_wr) begin
          state_nxt = start ? ARM : STOP;
        end else if (terminal) begin
          set_irq = 1'b1;
          if (periodic) begin
            count_nxt = reload;
          end else begin
            count_nxt = '1;
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end
        end else begin
          count_nxt = inc;
        end
      end
      default: state_nxt = STOP;
    endcase
  end

  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      state     <= STOP;
      count     <= '0;
      reload_q  <= '0;
      periodic  <= 1'b0;
      presc     <= '0;
      done_flag <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      done_flag <= done_nxt;
      if (wr_en && sel_lo) reload_q[7:0]  <= wr_data;
      if (wr_en && sel_hi) reload_q[15:8] <= wr_data;
      if (ctrl_wr) begin
        periodic <= wr_data[CTRL_PERIODIC];
        presc    <= wr_data[CTRL_PRESC_LSB +: PRESCALE_W];
      end
      if (set_irq)     irq <= 1'b1;
      else if (ack_wr) irq <= 1'b0;
    end
  end

`ifdef TIMER_CHAIN_CTRL_LATCH_EN
  logic [7:0] shadow;

  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      shadow <= '0;
    end else if (rd_en && sel_lo) begin
      shadow <= cnt_ext[15:8];
    end
  end

  assign hi_byte = shadow;
`else
  assign hi_byte = cnt_ext[15:8];
`endif

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      sel_lo:   rd_data = cnt_ext[7:0];
      sel_hi:   rd_data = hi_byte;
      sel_ctrl: rd_data = ctrl_byte(4'(presc), done_flag,
                                    periodic, running);
      sel_ack:  rd_data = '0;
      default:  rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_chain_ctrl.sv
// Bench for timer_chain_ctrl: directed scenarios plus randomized
// traffic against a behavioural model of the timer.
module tb_timer_chain_ctrl;

  logic        MasterClock = 1'b0;
  logic        RESETL = 1'b0;
  logic        CLK = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_data;
  logic        irq;
  logic [15:0] count;
  logic        running;

  int checks = 0;
  int errors = 0;

  // model of the programmer-visible timer
  logic [15:0] m_count, m_reload;
  logic [7:0]  m_shadow;
  logic [3:0]  m_div;
  int          m_strobes;
  bit          m_periodic, m_done, m_irq, m_arm, m_run;

  timer_chain_ctrl #(
    .WIDTH(16),
    .PRESCALE_W(4)
  ) dut (
    .MasterClock(MasterClock),
    .RESETL     (RESETL),
    .CLK        (CLK),
    .wr_en      (wr_en),
    .addr       (addr),
    .wr_data    (wr_data),
`ifdef TIMER_CHAIN_CTRL_LATCH_EN
    .rd_en      (rd_en),
`endif
    .rd_data    (rd_data),
    .irq        (irq),
    .count      (count),
    .running    (running)
  );

  always #5 MasterClock = ~MasterClock;

  task automatic model_reset;
    m_count = 0; m_reload = 0; m_shadow = 0; m_div = 0;
    m_strobes = 0; m_periodic = 0; m_done = 0; m_irq = 0;
    m_arm = 0; m_run = 0;
  endtask

  function automatic logic [7:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0: return m_count[7:0];
`ifdef TIMER_CHAIN_CTRL_LATCH_EN
      2'd1: return m_shadow;
`else
      2'd1: return m_count[15:8];
`endif
      2'd2: return {m_div, 1'b0, m_done, m_periodic, m_run};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step(input bit we, input logic [1:0] a,
                            input logic [7:0] d, input bit c,
                            input bit re);
    bit cw, ack, term;
    logic [15:0] nc;
    cw = we && a == 2'd2;
    ack = we && a == 2'd3;
    term = 0;
    nc = m_count;
`ifdef TIMER_CHAIN_CTRL_LATCH_EN
    if (re && a == 2'd0) m_shadow = m_count[15:8];
`endif
    if (m_arm) begin
      nc = m_reload; m_done = 0; m_strobes = 0;
      m_arm = cw && d[0];
      m_run = !cw;
    end else if (m_run) begin
      if (cw) begin
        m_run = 0; m_arm = d[0];
      end else if (c) begin
        m_strobes++;
        if (m_strobes % (int'(m_div) + 1) == 0) begin
          if (m_count == 16'hFFFF) begin
            term = 1;
            if (m_periodic) nc = m_reload;
            else begin m_done = 1; m_run = 0; end
          end else begin
            nc = m_count + 16'd1;
          end
        end
      end
    end else if (cw && d[0]) begin
      m_arm = 1;
    end
    if (term) m_irq = 1;
    else if (ack) m_irq = 0;
    if (cw) begin m_periodic = d[1]; m_div = d[7:4]; end
    if (we && a == 2'd0) m_reload[7:0] = d;
    if (we && a == 2'd1) m_reload[15:8] = d;
    m_count = nc;
  endtask

  task automatic cyc(input bit we, input logic [1:0] a,
                     input logic [7:0] d, input bit c, input bit re);
    wr_en = we; addr = a; wr_data = d; CLK = c; rd_en = re;
    model_step(we, a, d, c, re);
    @(posedge MasterClock); #1;
    wr_en = 0; CLK = 0; rd_en = 0;
  endtask

  task automatic peek(input logic [1:0] a);
    addr = a; wr_en = 0; CLK = 0; rd_en = 0;
    #1;
  endtask

  task automatic test_reset;
    RESETL = 0; wr_en = 0; CLK = 0; rd_en = 0; addr = 0;
    model_reset();
    repeat (2) @(posedge MasterClock);
    #1;
    checks++; if (count !== 16'h0000) begin errors++;
      $display("FAIL reset_count got=%h exp=0000", count); end
    checks++; if (irq !== 1'b0) begin errors++;
      $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (running !== 1'b0) begin errors++;
      $display("FAIL reset_running got=%b exp=0", running); end
    for (int a = 0; a < 4; a++) begin
      peek(2'(a));
      checks++; if (rd_data !== 8'h00) begin errors++;
        $display("FAIL reset_rd a=%0d got=%h exp=00", a, rd_data); end
    end
    RESETL = 1;
    @(posedge MasterClock); #1;
  endtask

  task automatic test_oneshot;
    logic [15:0] e;
    cyc(1, 2'd0, 8'hFC, 0, 0);
    cyc(1, 2'd1, 8'hFF, 0, 0);
    cyc(1, 2'd2, 8'h01, 0, 0);
    checks++; if (running !== 1'b0) begin errors++;
      $display("FAIL oneshot_arm_running got=%b exp=0", running); end
    cyc(0, 2'd0, 8'h00, 1, 0);
    checks++; if (count !== 16'hFFFC || running !== 1'b1) begin errors++;
      $display("FAIL oneshot_loaded got=%h/%b exp=fffc/1", count, running); end
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 2'd0, 8'h00, 1, 0);
      e = 16'hFFFC + 16'(k);
      checks++; if (count !== e || irq !== 1'b0) begin errors++;
        $display("FAIL oneshot_step%0d got=%h/%b exp=%h/0", k, count, irq, e); end
    end
    cyc(0, 2'd0, 8'h00, 1, 0);
    checks++; if (irq !== 1'b1 || count !== 16'hFFFF || running !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_term got=%b/%h/%b exp=1/ffff/0", irq, count, running);
    end
    peek(2'd2);
    checks++; if (rd_data !== 8'h04) begin errors++;
      $display("FAIL oneshot_ctrl got=%h exp=04", rd_data); end
    cyc(0, 2'd0, 8'h00, 1, 0);
    checks++; if (count !== 16'hFFFF) begin errors++;
      $display("FAIL oneshot_hold got=%h exp=ffff", count); end
    cyc(1, 2'd3, 8'h00, 0, 0);
    checks++; if (irq !== 1'b0) begin errors++;
      $display("FAIL oneshot_ack got=%b exp=0", irq); end
  endtask

  task automatic test_periodic;
    int strobes;
    bit ph, found;
    cyc(1, 2'd0, 8'hF0, 0, 0);
    cyc(1, 2'd1, 8'hFF, 0, 0);
    cyc(1, 2'd2, 8'h33, 0, 0);
    cyc(0, 2'd0, 8'h00, 0, 0);
    peek(2'd2);
    checks++; if (rd_data !== 8'h33) begin errors++;
      $display("FAIL periodic_ctrl got=%h exp=33", rd_data); end
    strobes = 0;
    ph = 1;
    for (int ev = 0; ev < 2; ev++) begin
      found = 0;
      for (int i = 0; i < 400 && !found; i++) begin
        cyc(0, 2'd0, 8'h00, ph, 0);
        if (ph) strobes++;
        ph = !ph;
        if (irq === 1'b1) found = 1;
      end
      checks++; if (!found || strobes != 64) begin errors++;
        $display("FAIL periodic_interval ev=%0d got=%0d exp=64", ev, strobes); end
      checks++; if (count !== 16'hFFF0) begin errors++;
        $display("FAIL periodic_reload ev=%0d got=%h exp=fff0", ev, count); end
      strobes = 0;
      cyc(1, 2'd3, 8'h00, ph, 0);
      if (ph) strobes++;
      ph = !ph;
      checks++; if (irq !== 1'b0) begin errors++;
        $display("FAIL periodic_ack ev=%0d got=%b exp=0", ev, irq); end
    end
  endtask

  task automatic test_ack_collision;
    cyc(1, 2'd0, 8'hFF, 0, 0);
    cyc(1, 2'd1, 8'hFF, 0, 0);
    cyc(1, 2'd2, 8'h03, 0, 0);
    cyc(0, 2'd0, 8'h00, 0, 0);
    checks++; if (count !== 16'hFFFF || running !== 1'b1) begin errors++;
      $display("FAIL ackcol_load got=%h/%b exp=ffff/1", count, running); end
    cyc(1, 2'd3, 8'h00, 1, 0);
    checks++; if (irq !== 1'b1 || count !== 16'hFFFF) begin errors++;
      $display("FAIL ackcol_setwins got=%b/%h exp=1/ffff", irq, count); end
    cyc(1, 2'd3, 8'h00, 0, 0);
    checks++; if (irq !== 1'b0) begin errors++;
      $display("FAIL ackcol_later got=%b exp=0", irq); end
  endtask

  task automatic test_stop_collision;
    cyc(1, 2'd2, 8'h00, 1, 0);
    checks++; if (running !== 1'b0 || count !== 16'hFFFF || irq !== 1'b0) begin
      errors++;
      $display("FAIL stopcol got=%b/%h/%b exp=0/ffff/0", running, count, irq);
    end
    peek(2'd2);
    checks++; if (rd_data !== 8'h00) begin errors++;
      $display("FAIL stopcol_ctrl got=%h exp=00", rd_data); end
  endtask

  task automatic test_reload_during_run;
    cyc(1, 2'd0, 8'hFE, 0, 0);
    cyc(1, 2'd1, 8'hFF, 0, 0);
    cyc(1, 2'd2, 8'h03, 0, 0);
    cyc(0, 2'd0, 8'h00, 0, 0);
    cyc(0, 2'd0, 8'h00, 1, 0);
    cyc(1, 2'd0, 8'h34, 0, 0);
    cyc(1, 2'd1, 8'h12, 0, 0);
    checks++; if (count !== 16'hFFFF) begin errors++;
      $display("FAIL rlrun_unaffected got=%h exp=ffff", count); end
    cyc(0, 2'd0, 8'h00, 1, 0);
    checks++; if (count !== 16'h1234 || irq !== 1'b1) begin errors++;
      $display("FAIL rlrun_reload got=%h/%b exp=1234/1", count, irq); end
    cyc(1, 2'd3, 8'h00, 1, 0);
    checks++; if (count !== 16'h1235 || irq !== 1'b0) begin errors++;
      $display("FAIL rlrun_next got=%h/%b exp=1235/0", count, irq); end
  endtask

  task automatic test_latch_carry;
    logic [7:0] e;
    cyc(1, 2'd2, 8'h00, 0, 0);
    cyc(1, 2'd0, 8'hFF, 0, 0);
    cyc(1, 2'd1, 8'h12, 0, 0);
    cyc(1, 2'd2, 8'h01, 0, 0);
    cyc(0, 2'd0, 8'h00, 0, 0);
    checks++; if (count !== 16'h12FF) begin errors++;
      $display("FAIL latch_load got=%h exp=12ff", count); end
    cyc(0, 2'd0, 8'h00, 1, 1);
    checks++; if (count !== 16'h1300) begin errors++;
      $display("FAIL latch_carry got=%h exp=1300", count); end
`ifdef TIMER_CHAIN_CTRL_LATCH_EN
    e = 8'h12;
`else
    e = 8'h13;
`endif
    peek(2'd1);
    checks++; if (rd_data !== e) begin errors++;
      $display("FAIL latch_hi got=%h exp=%h", rd_data, e); end
  endtask

  task automatic test_reset_mid;
    cyc(0, 2'd0, 8'h00, 1, 0);
    cyc(0, 2'd0, 8'h00, 1, 0);
    #2;
    RESETL = 0;
    #1;
    model_reset();
    checks++; if (count !== 16'h0000 || irq !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got=%h/%b/%b exp=0000/0/0", count, irq, running);
    end
    peek(2'd2);
    checks++; if (rd_data !== 8'h00) begin errors++;
      $display("FAIL reset_mid_ctrl got=%h exp=00", rd_data); end
    @(negedge MasterClock);
    RESETL = 1;
    @(posedge MasterClock); #1;
  endtask

  task automatic test_random;
    int r;
    bit we, c, re;
    logic [1:0] a, pa;
    logic [7:0] d;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      d = 8'($urandom_range(0, 255));
      c = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      a = 2'($urandom_range(0, 3));
      we = 0;
      if (r < 2) begin
        we = 1; a = 2'd2;
        d[0] = ($urandom_range(0, 7) != 0);
        d[7:4] = 4'($urandom_range(0, 2));
      end else if (r < 6) begin
        we = 1; a = 2'($urandom_range(0, 1));
        if (a == 2'd1 && $urandom_range(0, 3) != 0) d = 8'hFF;
        if (a == 2'd0 && $urandom_range(0, 3) != 0) d[7:4] = 4'hF;
      end else if (r < 9) begin
        we = 1; a = 2'd3;
      end
      cyc(we, a, d, c, re);
      checks++; if (count !== m_count) begin errors++;
        $display("FAIL rnd_count i=%0d got=%h exp=%h", i, count, m_count); end
      checks++; if (irq !== m_irq) begin errors++;
        $display("FAIL rnd_irq i=%0d got=%b exp=%b", i, irq, m_irq); end
      checks++; if (running !== m_run) begin errors++;
        $display("FAIL rnd_running i=%0d got=%b exp=%b", i, running, m_run); end
      pa = 2'($urandom_range(0, 3));
      peek(pa);
      checks++; if (rd_data !== model_rd(pa)) begin errors++;
        $display("FAIL rnd_rd i=%0d a=%0d got=%h exp=%h",
                 i, pa, rd_data, model_rd(pa));
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_ack_collision();
    test_stop_collision();
    test_reload_during_run();
    test_latch_carry();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
